// File: rtl/request_scheduler.sv
// Elevator hall-call scheduler: latches up/down calls, picks the next stop
// with a sweep rule, commands the motion controller, dwells at each stop and
// parks the car after a long idle stretch.
module request_scheduler #(
  parameter int DWELL_CYCLES = 16,
  parameter int PARK_TIMEOUT = 64
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_request,
  input  logic [2:0] i_request_floor,
  input  logic       i_request_dir,
  input  logic [1:0] i_traffic_state,
  input  logic [2:0] i_car_floor,
  input  logic       i_car_arrived,
  output logic [2:0] o_target_floor,
  output logic       o_move_req,
  output logic       o_door_open,
  output logic       o_sched_dir,
  output logic [7:0] o_pending_up,
  output logic [7:0] o_pending_down,
  output logic       o_busy
);
  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  // One spare code so the saturated idle count never wraps.
  localparam int IW = $clog2(PARK_TIMEOUT + 2);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_MOVE, S_DOOR, S_PARK} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_pend_up, r_pend_dn, w_any;
  logic [7:0]    w_set_up, w_set_dn, w_clr_up, w_clr_dn;
  logic [2:0]    r_target, w_park_floor;
  logic          r_sched_dir, r_served_dir;
  logic [DW-1:0] r_dwell;
  logic [IW-1:0] r_idle, w_idle_inc;
  logic          w_door_hit, w_idle_expired, w_dwell_done;
  logic          w_up_hit, w_up_srv, w_dn_hit, w_dn_srv;
  logic [2:0]    w_up_floor, w_dn_floor;
  logic          w_sel_hit, w_sel_srv, w_sel_flip;
  logic [2:0]    w_sel_floor;

  assign w_any          = r_pend_up | r_pend_dn;
  assign w_idle_inc     = r_idle + IW'(1);
  assign w_idle_expired = (w_idle_inc >= IW'(PARK_TIMEOUT));
  assign w_dwell_done   = (r_dwell == DW'(DWELL_CYCLES - 1));

  // A repeat of the call being served while the doors are open only
  // extends the dwell; it must not re-latch.
  assign w_door_hit = (r_state == S_DOOR) && i_request &&
                      (i_request_floor == i_car_floor) && (i_request_dir == r_served_dir);
  assign w_set_up = (i_request &&  i_request_dir && !w_door_hit) ? (8'd1 << i_request_floor) : 8'd0;
  assign w_set_dn = (i_request && !i_request_dir && !w_door_hit) ? (8'd1 << i_request_floor) : 8'd0;

  // Park floor chosen by traffic mode.
  always_comb begin
    case (i_traffic_state)
      2'd2:    w_park_floor = 3'd7;
      2'd3:    w_park_floor = 3'd3;
      default: w_park_floor = 3'd0;
    endcase
  end

  // Upward sweep: nearest up call at/above the car, else the farthest call above.
  always_comb begin
    w_up_hit   = 1'b0;
    w_up_floor = '0;
    w_up_srv   = 1'b1;
    for (int f = 7; f >= 0; f--)
      if (r_pend_up[f] && (3'(f) >= i_car_floor)) begin
        w_up_hit   = 1'b1;
        w_up_floor = 3'(f);
      end
    // Any call above at this point is a down call.
    if (!w_up_hit)
      for (int f = 0; f < 8; f++)
        if (w_any[f] && (3'(f) > i_car_floor)) begin
          w_up_hit   = 1'b1;
          w_up_floor = 3'(f);
          w_up_srv   = 1'b0;
        end
  end

  // Downward sweep: nearest down call at/below the car, else the farthest call below.
  always_comb begin
    w_dn_hit   = 1'b0;
    w_dn_floor = '0;
    w_dn_srv   = 1'b0;
    for (int f = 0; f < 8; f++)
      if (r_pend_dn[f] && (3'(f) <= i_car_floor)) begin
        w_dn_hit   = 1'b1;
        w_dn_floor = 3'(f);
      end
    if (!w_dn_hit)
      for (int f = 7; f >= 0; f--)
        if (w_any[f] && (3'(f) < i_car_floor)) begin
          w_dn_hit   = 1'b1;
          w_dn_floor = 3'(f);
          w_dn_srv   = 1'b1;
        end
  end

  // Try the current sweep direction first, reverse only if it finds nothing.
  always_comb begin
    w_sel_flip = 1'b0;
    if (r_sched_dir) begin
      w_sel_hit   = w_up_hit;
      w_sel_floor = w_up_floor;
      w_sel_srv   = w_up_srv;
      if (!w_up_hit) begin
        w_sel_hit   = w_dn_hit;
        w_sel_floor = w_dn_floor;
        w_sel_srv   = w_dn_srv;
        w_sel_flip  = w_dn_hit;
      end
    end else begin
      w_sel_hit   = w_dn_hit;
      w_sel_floor = w_dn_floor;
      w_sel_srv   = w_dn_srv;
      if (!w_dn_hit) begin
        w_sel_hit   = w_up_hit;
        w_sel_floor = w_up_floor;
        w_sel_srv   = w_up_srv;
        w_sel_flip  = w_up_hit;
      end
    end
  end

  // Next-state and served-call clear decode.
  always_comb begin
    w_state_nxt = r_state;
    w_clr_up    = '0;
    w_clr_dn    = '0;
    case (r_state)
      S_IDLE:
        if (|w_any) w_state_nxt = S_SELECT;
        else if (w_idle_expired && (i_car_floor != w_park_floor)) w_state_nxt = S_PARK;
      S_SELECT:
        if (!w_sel_hit) w_state_nxt = S_IDLE;
        else if (w_sel_floor == i_car_floor) begin
          w_state_nxt = S_DOOR;
          if (w_sel_srv) w_clr_up = 8'd1 << w_sel_floor;
          else           w_clr_dn = 8'd1 << w_sel_floor;
        end else w_state_nxt = S_MOVE;
      S_MOVE:
        if (i_car_arrived) begin
          w_state_nxt = S_DOOR;
          if (r_served_dir) w_clr_up = 8'd1 << r_target;
          else              w_clr_dn = 8'd1 << r_target;
        end
      S_DOOR:
        if (!w_door_hit && w_dwell_done) w_state_nxt = (|w_any) ? S_SELECT : S_IDLE;
      S_PARK:
        if (i_car_arrived) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Call bitmaps; a set beats a clear on the same bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pend_up <= '0;
      r_pend_dn <= '0;
    end else begin
      r_pend_up <= (r_pend_up & ~w_clr_up) | w_set_up;
      r_pend_dn <= (r_pend_dn & ~w_clr_dn) | w_set_dn;
    end
  end

  // Destination and direction bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_target     <= '0;
      r_sched_dir  <= 1'b1;
      r_served_dir <= 1'b1;
    end else begin
      if (r_state == S_SELECT && w_sel_hit) begin
        r_served_dir <= w_sel_srv;
        if (w_sel_flip) r_sched_dir <= ~r_sched_dir;
        if (w_sel_floor != i_car_floor) r_target <= w_sel_floor;
      end
      if (r_state == S_MOVE && i_car_arrived) r_sched_dir <= r_served_dir;
      if (r_state == S_IDLE && w_state_nxt == S_PARK) r_target <= w_park_floor;
    end
  end

  // Dwell and idle counters; both rest at zero outside their state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dwell <= '0;
      r_idle  <= '0;
    end else begin
      if (r_state == S_DOOR && w_state_nxt == S_DOOR && !w_door_hit) r_dwell <= r_dwell + DW'(1);
      else                                                            r_dwell <= '0;
      if (r_state == S_IDLE && w_state_nxt == S_IDLE)
        r_idle <= w_idle_expired ? IW'(PARK_TIMEOUT) : w_idle_inc;
      else
        r_idle <= '0;
    end
  end

  assign o_target_floor = r_target;
  assign o_move_req     = (r_state == S_MOVE) || (r_state == S_PARK);
  assign o_door_open    = (r_state == S_DOOR);
  assign o_busy         = (r_state != S_IDLE);
  assign o_sched_dir    = r_sched_dir;
  assign o_pending_up   = r_pend_up;
  assign o_pending_down = r_pend_dn;
endmodule

// File: doc/request_scheduler.md
REQUEST_SCHEDULER -- requirements
Module: request_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 16, door-open dwell length in clock cycles.
REQ-002 Parameter PARK_TIMEOUT, default 64, idle cycles before the car parks.
REQ-003 One clock; reset is asynchronous and active-low. Ports: clk in 1, reset in 1 (reset=0 asserts).
REQ-004 request  in  1  single-cycle hall-call strobe.
REQ-005 request_floor  in  3  hall-call floor, 0-7.
REQ-006 request_dir  in  1  hall-call direction, 1=up, 0=down.
REQ-007 traffic_state  in  2  traffic mode; selects the park floor.
REQ-008 car_floor  in  3  current car floor from the motion controller.
REQ-009 car_arrived  in  1  single-cycle pulse: car stopped at target_floor.
REQ-010 target_floor  out  3  registered destination floor.
REQ-011 move_req  out  1  request to the motion controller; target_floor stays stable while it is high.
REQ-012 door_open  out  1  doors commanded open.
REQ-013 sched_dir  out  1  current sweep direction, 1=up.
REQ-014 pending_up, pending_down  out  8 each  latched call bitmaps, bit n = floor n.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 request=1 shall set pending_up[request_floor] if request_dir=1, else pending_down[request_floor], visible the next cycle; this holds for any floor, including up@7 and down@0.
REQ-017 If a set and a clear hit the same bit in the same cycle, the set shall win.
REQ-018 States: IDLE, SELECT, MOVE, DOOR, PARK. All transitions shall be registered, one per clock.
REQ-019 IDLE: if any pending bit is set, go to SELECT. Otherwise increment the idle counter. When the counter reaches PARK_TIMEOUT and car_floor is not the park floor, go to PARK. The counter clears on leaving IDLE.
REQ-020 Park floor mapping: traffic_state 0->0, 1->0, 2->7, 3->3.
REQ-021 SELECT, sched_dir=1: target = lowest f>=car_floor with pending_up[f]; else highest f>car_floor with any call; else flip sched_dir and apply the mirror rule. Set served_dir to the direction of the chosen call.
REQ-022 Mirror rule: target = highest f<=car_floor with pending_down[f]; else lowest f<car_floor with any call; else flip. If no call exists in either direction, go to IDLE.
REQ-023 SELECT exit: if target equals car_floor, go to DOOR and clear the served bit; otherwise load target_floor and go to MOVE.
REQ-024 MOVE: move_req=1. On car_arrived, go to DOOR, clear pending_{served_dir}[target_floor], and set sched_dir=served_dir.
REQ-025 DOOR: door_open=1 for DWELL_CYCLES cycles. Then go to SELECT if any call is pending, else IDLE.
REQ-026 In DOOR, a request matching car_floor and served_dir shall not be latched and shall reload the dwell counter.
REQ-027 PARK: move_req=1 with target_floor = park floor. New requests are latched but do not abort the move. On car_arrived, go to IDLE with no door cycle.
REQ-028 car_arrived outside MOVE or PARK shall be ignored.
REQ-029 move_req, door_open and busy shall be decoded from the registered state; there is no combinational path from inputs to any output.

Reset
REQ-030 While reset=0: state IDLE, pending bitmaps 0, target_floor 0, sched_dir 1, served_dir 1, move_req 0, door_open 0, busy 0, all counters 0.
REQ-031 Asserting reset mid-MOVE, DOOR or PARK shall force the REQ-030 values immediately and discard all pending calls.

Verification
REQ-032 car_floor=0; up call at floor 3, then down call at floor 5 the next cycle.
 -> pending_up=0x08, pending_down=0x20.
 -> SELECT picks 3: move_req=1, target_floor=3.
 -> car_arrived: door_open=1 for 16 cycles, pending_up=0x00.
 -> SELECT picks 5: target_floor=5, served_dir=0.
REQ-033 Idle at floor 2, traffic_state=2, no calls.
 -> after 64 idle cycles: PARK, move_req=1, target_floor=7.
 -> car_arrived: IDLE, door_open never asserted.
REQ-034 car_floor=4, up call at floor 4.
 -> SELECT then DOOR, with no move_req.
 -> a repeat up@4 during DOOR reloads dwell; pending_up stays 0x00.
REQ-035 car_floor=6, sched_dir=1, calls down@1 and up@2.
 -> target_floor=1 (highest-any-above fails, reverse; highest down <=6 is 1).
 -> sched_dir=0.
REQ-036 Reset asserted in MOVE with pending_up=0xFF.
 -> next edge: all outputs at reset values.
 -> car_arrived after release is ignored.
REQ-037 request for floor 3 up in the same cycle as the clear of pending_up[3].
 -> bit 3 remains set.
